// File: rtl/count_ones.sv
// Registered population counter: pairwise adder tree over in_s,
// saturated to CNT_W bits, one output register stage.
module count_ones #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_s,
  output logic [CNT_W-1:0] n_one,
  output logic             n_sat
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int LVLS = $clog2(WIDTH);
  localparam int P    = 1 << LVLS;
  localparam int MAXV = (1 << CNT_W) - 1;

  logic [CW-1:0]    w_true_cnt;
  logic             w_sat;
  logic [CNT_W-1:0] w_one;
  logic [CNT_W-1:0] r_one;
  logic             r_sat;

  // In-place tree: pass k folds pairs (2i, 2i+1) into slot i.
  always_comb begin
    logic [CW-1:0] t [P];
    int n;
    for (int i = 0; i < P; i++) begin
      t[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = {{(CW-1){1'b0}}, in_s[i]};
    end
    n = P;
    for (int k = 0; k < LVLS; k++) begin
      n = n / 2;
      for (int i = 0; i < P / 2; i++) begin
        if (i < n) begin
          t[i] = t[2*i] + t[2*i+1];
        end
      end
    end
    w_true_cnt = t[0];
  end

  assign w_sat = (int'(w_true_cnt) > MAXV);
  assign w_one = w_sat ? {CNT_W{1'b1}} : CNT_W'(w_true_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_one <= '0;
      r_sat <= 1'b0;
    end else begin
      r_one <= w_one;
      r_sat <= w_sat;
    end
  end

  assign n_one = r_one;
  assign n_sat = r_sat;

endmodule

// File: tb/tb_count_ones.sv
// Directed and random checks for count_ones.
// Outputs sampled 1 time unit after each rising edge.
module tb_count_ones;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_s;
  logic [3:0]  n_one;
  logic        n_sat;

  int n_checks;
  int n_fail;

  count_ones #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_s  (in_s),
    .n_one (n_one),
    .n_sat (n_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] eo,
                     input logic es);
    n_checks++;
    assert (n_one === eo) else begin
      n_fail++;
      $error("FAIL %s n_one=%0h expected %0h", tag, n_one, eo);
    end
    n_checks++;
    assert (n_sat === es) else begin
      n_fail++;
      $error("FAIL %s n_sat=%0b expected %0b", tag, n_sat, es);
    end
  endtask

  task automatic step(input logic [15:0] w);
    in_s = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    int pc;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    in_s     = 16'hFFFF;

    // asynchronous reset: no clock edge needed
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_held", 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", 4'hF, 1'b1);

    // previous value held until the next edge
    in_s = 16'hA50F;
    #2;
    chk("hold_before_edge", 4'hF, 1'b1);
    @(posedge clk);
    #1;
    chk("single_A50F", 4'h8, 1'b0);

    step(16'h0000); chk("ext_0000", 4'h0, 1'b0);
    step(16'h0001); chk("ext_0001", 4'h1, 1'b0);
    step(16'h8000); chk("ext_8000", 4'h1, 1'b0);
    step(16'h7FFF); chk("ext_7FFF", 4'hF, 1'b0);
    step(16'hFFFF); chk("ext_FFFF", 4'hF, 1'b1);
    step(16'h0000); chk("ext_clear", 4'h0, 1'b0);

    // back-to-back words on consecutive edges
    step(16'h00FF); chk("b2b_00FF", 4'h8, 1'b0);
    step(16'h0F0F); chk("b2b_0F0F", 4'h8, 1'b0);
    step(16'h1111); chk("b2b_1111", 4'h4, 1'b0);

    // mid-stream reset pulse between edges
    in_s = 16'hF0F0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_drop", 4'h0, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_reset_no_stale", 4'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_reset_after", 4'h8, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      w = 16'($urandom);
      if (i == 500) w = 16'hFFFF;
      pc = $countones(w);
      step(w);
      chk("random", (pc > 15) ? 4'hF : 4'(pc), pc == 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
